// File: rtl/motor_pkg.sv
// Shared types and constants for the motor speed command path.
package motor_pkg;

   // Command FSM states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2,
      DEAD     = 2'd3
   } motor_state_t;

   // Bridge direction encoding
   localparam logic FWD = 1'b0;
   localparam logic REV = 1'b1;

endpackage

// File: rtl/motor_cmd_map.sv
// Pot sample to speed target mapping: optional 4-tap averaging, then
// mid-scale offset, deadband, scale to duty and saturate.
// Optional feature macro: MOTOR_CMD_FILTER_EN (adds the moving average stage,
// which costs one extra cycle of latency on tgt_valid_o).
module motor_cmd_map
   import motor_pkg::*;
#(
   parameter int ADC_W    = 12,
   parameter int DUTY_W   = 9,
   parameter int DUTY_MAX = 320,
   parameter int DEADBAND = 64
) (
`ifdef MOTOR_CMD_FILTER_EN
   input  logic              clk_i,
   input  logic              rst_n_i,
`endif
   input  logic              sample_valid_i,
   input  logic [ADC_W-1:0]  sample_i,
   output logic [DUTY_W-1:0] tgt_o,
   output logic              tdir_o,
   output logic              tgt_valid_o
);

   localparam int PROD_W = ADC_W + DUTY_W;
   localparam int MID    = 1 << (ADC_W - 1);
   localparam logic signed [ADC_W:0] MID_S = (ADC_W+1)'(MID);

   // Magnitude of the signed offset; -2^(ADC_W-1) maps to 2^(ADC_W-1), which still fits ADC_W bits
   function automatic logic [ADC_W-1:0] abs_mag(input logic signed [ADC_W:0] d);
      logic signed [ADC_W:0] a;
      a = d[ADC_W] ? -d : d;
      return a[ADC_W-1:0];
   endfunction

   // Deadband, scale to duty range and clamp at full scale
   function automatic logic [DUTY_W-1:0] scale_sat(input logic [ADC_W-1:0] mag);
      logic [ADC_W-1:0]  excess;
      logic [PROD_W-1:0] prod;
      logic [PROD_W-1:0] shifted;
      if (mag < ADC_W'(DEADBAND)) begin
         return '0;
      end
      excess  = mag - ADC_W'(DEADBAND);
      prod    = PROD_W'(excess) * PROD_W'(DUTY_MAX);
      shifted = prod >> (ADC_W - 1);
      if (shifted > PROD_W'(DUTY_MAX)) begin
         return DUTY_W'(DUTY_MAX);
      end
      return shifted[DUTY_W-1:0];
   endfunction

   logic [ADC_W-1:0]      map_sample;
   logic                  map_valid;
   logic signed [ADC_W:0] d;

`ifdef MOTOR_CMD_FILTER_EN
   logic [ADC_W-1:0] h0_q, h1_q, h2_q;
   logic [ADC_W-1:0] avg_p0_q;
   logic             vld_p0_q;
   logic [ADC_W+1:0] sum_p0;

   // Four-tap sum; two bits of growth make overflow impossible
   always_comb begin
      sum_p0 = (ADC_W+2)'(sample_i) + (ADC_W+2)'(h0_q) + (ADC_W+2)'(h1_q) + (ADC_W+2)'(h2_q);
   end

   // Stage p0: shift history and register the average on each new sample
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         h0_q     <= ADC_W'(MID);
         h1_q     <= ADC_W'(MID);
         h2_q     <= ADC_W'(MID);
         avg_p0_q <= ADC_W'(MID);
         vld_p0_q <= 1'b0;
      end else begin
         vld_p0_q <= sample_valid_i;
         if (sample_valid_i) begin
            h0_q     <= sample_i;
            h1_q     <= h0_q;
            h2_q     <= h1_q;
            avg_p0_q <= sum_p0[ADC_W+1:2];
         end
      end
   end

   assign map_sample = avg_p0_q;
   assign map_valid  = vld_p0_q;
`else
   assign map_sample = sample_i;
   assign map_valid  = sample_valid_i;
`endif

   // Signed offset from mid-scale, direction from its sign, duty target from its magnitude
   always_comb begin
      d      = $signed({1'b0, map_sample}) - MID_S;
      tdir_o = d[ADC_W] ? REV : FWD;
      tgt_o  = scale_sat(abs_mag(d));
   end

   assign tgt_valid_o = map_valid;

endmodule

// File: rtl/motor_speed_ctrl.sv
// Motor speed command stage: maps pot samples to a signed speed, slew-limits
// duty, and sequences H-bridge direction changes through a zero-duty dead time.
// Optional feature macro: MOTOR_CMD_FILTER_EN (4-tap sample averaging in motor_cmd_map).
module motor_speed_ctrl
   import motor_pkg::*;
#(
   parameter int ADC_W      = 12,
   parameter int DUTY_W     = 9,
   parameter int DUTY_MAX   = 320,
   parameter int DEADBAND   = 64,
   parameter int RAMP_TICKS = 6000,
   parameter int RAMP_STEP  = 4,
   parameter int DEAD_TICKS = 12000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [ADC_W-1:0]  sample,
   input  logic              enable,
   output logic [DUTY_W-1:0] duty,
   output logic              in1,
   output logic              in2,
   output logic              at_target
);

   localparam int TICK_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam int DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
   localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);

   // Move cur toward goal by at most one ramp step, landing exactly on goal
   function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                     input logic [DUTY_W-1:0] goal);
      if (cur < goal) begin
         return ((goal - cur) > STEP) ? (cur + STEP) : goal;
      end
      return ((cur - goal) > STEP) ? (cur - STEP) : goal;
   endfunction

   logic [DUTY_W-1:0] map_tgt;
   logic              map_tdir;
   logic              map_valid;

   logic [DUTY_W-1:0] tgt_q;
   logic              tdir_q;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic              step;
   motor_state_t      state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              dir_q, dir_d;
   logic [DEAD_W-1:0] dead_q, dead_d;

   motor_cmd_map #(
      .ADC_W    (ADC_W),
      .DUTY_W   (DUTY_W),
      .DUTY_MAX (DUTY_MAX),
      .DEADBAND (DEADBAND)
   ) u_map (
`ifdef MOTOR_CMD_FILTER_EN
      .clk_i          (clk),
      .rst_n_i        (rst_n),
`endif
      .sample_valid_i (sample_valid),
      .sample_i       (sample),
      .tgt_o          (map_tgt),
      .tdir_o         (map_tdir),
      .tgt_valid_o    (map_valid)
   );

   // Hold the latest mapped target until the next sample replaces it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_q  <= '0;
         tdir_q <= FWD;
      end else if (map_valid) begin
         tgt_q  <= map_tgt;
         tdir_q <= map_tdir;
      end
   end

   // Free-running ramp divider; a step fires on the wrap cycle
   always_comb begin
      step   = (tick_q == TICK_W'(RAMP_TICKS - 1));
      tick_d = step ? '0 : tick_q + 1'b1;
   end

   // Ramp divider register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= '0;
      end else begin
         tick_q <= tick_d;
      end
   end

   // FSM state register together with duty, latched direction and dead counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         duty_q  <= '0;
         dir_q   <= FWD;
         dead_q  <= '0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         dir_q   <= dir_d;
         dead_q  <= dead_d;
      end
   end

   // Next-state logic; direction only ever changes while duty is zero
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      dead_d  = dead_q;
      if (!enable) begin
         state_d = DEAD;
         duty_d  = '0;
         dead_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               duty_d = '0;
               if (tgt_q != '0) begin
                  state_d = RUN;
                  dir_d   = tdir_q;
               end
            end
            RUN: begin
               if ((tgt_q != '0) && (tdir_q != dir_q)) begin
                  state_d = STOPPING;
               end else if ((tgt_q == '0) && (duty_q == '0)) begin
                  state_d = IDLE;
               end else if (step) begin
                  duty_d = step_toward(duty_q, tgt_q);
               end
            end
            STOPPING: begin
               if ((tgt_q != '0) && (tdir_q == dir_q)) begin
                  state_d = RUN;
               end else if (duty_q == '0) begin
                  state_d = DEAD;
                  dead_d  = '0;
               end else if (step) begin
                  duty_d = step_toward(duty_q, '0);
               end
            end
            DEAD: begin
               duty_d = '0;
               if (dead_q == DEAD_W'(DEAD_TICKS - 1)) begin
                  dead_d = '0;
                  if (tgt_q == '0) begin
                     state_d = IDLE;
                  end else begin
                     state_d = RUN;
                     dir_d   = tdir_q;
                  end
               end else begin
                  dead_d = dead_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               duty_d  = '0;
            end
         endcase
      end
   end

   // Outputs: bridge driven only in RUN/STOPPING, never both legs at once
   always_comb begin
      in1       = 1'b0;
      in2       = 1'b0;
      duty      = duty_q;
      at_target = 1'b0;
      if ((state_q == RUN) || (state_q == STOPPING)) begin
         in1 = (dir_q == FWD);
         in2 = (dir_q == REV);
      end
      if ((state_q == IDLE) && (tgt_q == '0)) begin
         at_target = 1'b1;
      end
      if ((state_q == RUN) && (duty_q == tgt_q) && (dir_q == tdir_q)) begin
         at_target = 1'b1;
      end
   end

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Directed bench for motor_speed_ctrl with a duty-change scoreboard.
// Build with MOTOR_CMD_FILTER_EN defined to exercise the averaging path.
module tb_motor_speed_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] sample = 12'd2048;
   logic        enable = 1'b1;
   logic [8:0]  duty;
   logic        in1, in2, at_target;

   int checks = 0;
   int failures = 0;
   int zero_cnt = 0;

   typedef struct {
      int duty;
      int in1;
      int in2;
      int gap;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   motor_speed_ctrl #(
      .ADC_W      (12),
      .DUTY_W     (9),
      .DUTY_MAX   (320),
      .DEADBAND   (64),
      .RAMP_TICKS (4),
      .RAMP_STEP  (4),
      .DEAD_TICKS (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample       (sample),
      .enable       (enable),
      .duty         (duty),
      .in1          (in1),
      .in2          (in2),
      .at_target    (at_target)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected duty trajectory: steps of 4 toward goal, 4 clocks apart after the first
   task automatic push_ramp(input int from, input int goal, input int e1, input int e2);
      int   d;
      bit   first;
      exp_t e;
      d     = from;
      first = 1'b1;
      while (d != goal) begin
         if (goal > d) d = d + ((goal - d) > 4 ? 4 : (goal - d));
         else          d = d - ((d - goal) > 4 ? 4 : (d - goal));
         e.duty = d;
         e.in1  = e1;
         e.in2  = e2;
         e.gap  = first ? 0 : 4;
         sbq.push_back(e);
         first = 1'b0;
      end
   endtask

   task automatic strobe(input int val);
      sample       = 12'(val);
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_sb(input string tag, input int budget);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_sb_drained"}, sbq.size(), 0);
   endtask

   task automatic chk_outs(input string tag, input int e_duty, input int e1, input int e2, input int e_at);
      chk({tag, "_duty"}, int'(duty), e_duty);
      chk({tag, "_in1"}, int'(in1), e1);
      chk({tag, "_in2"}, int'(in2), e2);
      chk({tag, "_at_target"}, int'(at_target), e_at);
   endtask

   // Monitor: safety properties every cycle, scoreboard pop on every duty change
   initial begin
      int   prev_duty;
      int   prev_pins;
      int   cur_pins;
      int   gap;
      exp_t e;
      prev_duty = 0;
      prev_pins = 0;
      gap       = 0;
      forever begin
         @(negedge clk);
         cur_pins = int'({in1, in2});
         if (!rst_n) begin
            prev_duty = int'(duty);
            prev_pins = cur_pins;
            gap       = 0;
         end else begin
            gap++;
            chk("excl_pins", int'(in1 & in2), 0);
            chk("duty_le_max", int'(duty <= 9'd320), 1);
            if (cur_pins != prev_pins) chk("pin_change_at_duty0", int'(duty), 0);
            if (enable && !in1 && !in2) zero_cnt++;
            if (int'(duty) != prev_duty) begin
               if (sbq.size() == 0) begin
                  checks++;
                  failures++;
                  $error("FAIL sb_unexpected_duty observed=%0d expected=no change", duty);
               end else begin
                  e = sbq.pop_front();
                  chk("sb_duty", int'(duty), e.duty);
                  chk("sb_in1", int'(in1), e.in1);
                  chk("sb_in2", int'(in2), e.in2);
                  if (e.gap != 0) chk("sb_step_gap", gap, e.gap);
               end
               gap = 0;
            end
            prev_duty = int'(duty);
            prev_pins = cur_pins;
         end
      end
   end

   initial begin
      exp_t e;
      // Reset state
      cycles(3);
      chk_outs("reset", 0, 0, 0, 1);
      rst_n = 1'b1;
      cycles(2);

`ifdef MOTOR_CMD_FILTER_EN
      // Averaged path: three mid-scale samples then full scale -> avg 2559 -> tgt 69
      strobe(2048); cycles(2);
      strobe(2048); cycles(2);
      strobe(2048); cycles(2);
      chk_outs("f_mid", 0, 0, 0, 1);
      push_ramp(0, 69, 1, 0);
      strobe(4095);
      chk("f_lat_cycle1_at_target", int'(at_target), 1);
      cycles(1);
      chk("f_lat_cycle2_at_target", int'(at_target), 0);
      wait_sb("f_ramp", 1000);
      cycles(1);
      chk_outs("f_settled", 69, 1, 0, 1);
`else
      // Stop band: centre, just inside and at the deadband edge, both sides
      strobe(2048);        cycles(3); chk_outs("idle_mid", 0, 0, 0, 1);
      strobe(2048 + 63);   cycles(3); chk_outs("idle_db63", 0, 0, 0, 1);
      strobe(2048 + 64);   cycles(3); chk_outs("idle_db64", 0, 0, 0, 1);
      strobe(2048 - 63);   cycles(3); chk_outs("idle_db_neg", 0, 0, 0, 1);

      // Full forward: ramp to 309, last step of 1
      push_ramp(0, 309, 1, 0);
      strobe(4095);
      chk("fwd_latency_at_target", int'(at_target), 0);
      wait_sb("fwd_ramp", 2000);
      cycles(1);
      chk_outs("fwd_settled", 309, 1, 0, 1);

      // Reversal: ramp down on in1, 8 coast cycles, ramp up on in2 to 310
      zero_cnt = 0;
      push_ramp(309, 0, 1, 0);
      push_ramp(0, 310, 0, 1);
      strobe(0);
      wait_sb("reverse", 3000);
      chk("reverse_dead_cycles", zero_cnt, 8);
      cycles(1);
      chk_outs("rev_settled", 310, 0, 1, 1);

      // Back to centre: ramp down in RUN, then IDLE
      push_ramp(310, 0, 0, 1);
      strobe(2048);
      wait_sb("to_idle", 2000);
      cycles(2);
      chk_outs("back_idle", 0, 0, 0, 1);

      // Enable drop at duty 200, then dead time on re-enable
      push_ramp(0, 200, 1, 0);
      strobe(4095);
      wait_sb("pre_disable", 2000);
      chk("pre_disable_duty", int'(duty), 200);
      e.duty = 0; e.in1 = 0; e.in2 = 0; e.gap = 0;
      sbq.push_back(e);
      enable = 1'b0;
      cycles(1);
      chk_outs("disabled", 0, 0, 0, 0);
      cycles(4);
      chk_outs("disabled_hold", 0, 0, 0, 0);
      zero_cnt = 0;
      push_ramp(0, 100, 1, 0);
      enable = 1'b1;
      wait_sb("reenable", 2000);
      chk("reenable_dead_cycles", zero_cnt, 8);

      // Asynchronous reset mid-ramp
      chk("pre_reset_duty", int'(duty), 100);
      #3;
      rst_n = 1'b0;
      #1;
      chk_outs("async_reset", 0, 0, 0, 1);
      cycles(2);
      rst_n = 1'b1;
      cycles(10);
      chk_outs("post_reset_idle", 0, 0, 0, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
